// File: rtl/dma_io_peripheral_if.sv
// DMA controller channel bus: request/acknowledge handshake,
// I/O strobes, end-of-process and the device data bus.
interface dma_io_peripheral_if #(
    parameter int WIDTH = 8
);
    logic             DREQ;
    logic             DACK;
    logic             IOR_N;
    logic             IOW_N;
    logic             EOP_N;
    logic [WIDTH-1:0] DB_IN;
    logic [WIDTH-1:0] DB_OUT;
    logic             DB_OE;

    modport master (
        output DACK,
        output IOR_N,
        output IOW_N,
        output EOP_N,
        output DB_IN,
        input  DREQ,
        input  DB_OUT,
        input  DB_OE
    );

    modport slave (
        input  DACK,
        input  IOR_N,
        input  IOW_N,
        input  EOP_N,
        input  DB_IN,
        output DREQ,
        output DB_OUT,
        output DB_OE
    );
endinterface

// File: rtl/dma_io_peripheral.sv
// Single-transfer DMA I/O peripheral with a source FIFO feeding
// bus reads and a sink FIFO collecting bus writes.
module dma_io_peripheral #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    dma_io_peripheral_if.slave   bus,
    input  logic                 enable,
    input  logic                 dir,
    input  logic                 src_valid,
    input  logic [WIDTH-1:0]     src_data,
    output logic                 src_ready,
    output logic                 snk_valid,
    output logic [WIDTH-1:0]     snk_data,
    input  logic                 snk_ready,
    output logic                 tc_flag,
    input  logic                 tc_clr,
    output logic                 ovf_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        REQ   = 4'b0010,
        XFER  = 4'b0100,
        RECOV = 4'b1000
    } state_t;

    state_t st;
    state_t nxt;
    logic   dreq;

    logic [WIDTH-1:0] src_mem [DEPTH];
    logic [WIDTH-1:0] snk_mem [DEPTH];
    logic [AW:0]      src_wp;
    logic [AW:0]      src_rp;
    logic [AW:0]      snk_wp;
    logic [AW:0]      snk_rp;

    logic src_empty;
    logic src_full;
    logic snk_empty;
    logic snk_full;

    logic             rd_q;
    logic             wr_q;
    logic [WIDTH-1:0] db_q;

    logic in_xfer;
    logic rd_act;
    logic wr_act;
    logic rd_done;
    logic wr_done;
    logic src_pop;
    logic src_push;
    logic snk_pop;
    logic snk_push;
    logic ovf_set;
    logic eop_hit;

    assign src_empty = (src_wp == src_rp);
    assign src_full  = (src_wp[AW] != src_rp[AW]) &&
                       (src_wp[AW-1:0] == src_rp[AW-1:0]);
    assign snk_empty = (snk_wp == snk_rp);
    assign snk_full  = (snk_wp[AW] != snk_rp[AW]) &&
                       (snk_wp[AW-1:0] == snk_rp[AW-1:0]);

    // Strobes only count while acknowledged and matching the direction.
    assign in_xfer = (st == XFER);
    assign rd_act  = in_xfer && bus.DACK && !bus.IOR_N && !dir;
    assign wr_act  = in_xfer && bus.DACK && !bus.IOW_N && dir;
    assign rd_done = in_xfer && rd_q && bus.IOR_N;
    assign wr_done = in_xfer && wr_q && bus.IOW_N;

    // A pop frees the slot, so a push into a full FIFO is still taken.
    assign src_pop  = rd_done && !src_empty;
    assign src_push = src_valid && (!src_full || src_pop);
    assign snk_pop  = snk_ready && !snk_empty;
    assign snk_push = wr_done && (!snk_full || snk_pop);
    assign ovf_set  = wr_done && snk_full && !snk_pop;
    assign eop_hit  = !bus.EOP_N && bus.DACK;

    assign src_ready  = !src_full;
    assign snk_valid  = !snk_empty;
    assign snk_data   = snk_mem[snk_rp[AW-1:0]];
    assign bus.DREQ   = dreq;
    assign bus.DB_OE  = rd_act;
    assign bus.DB_OUT = src_empty ? '0 : src_mem[src_rp[AW-1:0]];

    always_comb begin
        nxt = st;
        case (st)
            IDLE: begin
                if (enable && !tc_flag &&
                    (dir ? !snk_full : !src_empty))
                    nxt = REQ;
            end
            REQ: begin
                if (bus.DACK)
                    nxt = XFER;
                else if (!enable)
                    nxt = IDLE;
            end
            XFER: begin
                if (rd_done || wr_done)
                    nxt = RECOV;
                else if (!bus.DACK)
                    nxt = REQ;
            end
            RECOV:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st   <= IDLE;
            dreq <= 1'b0;
        end else begin
            st   <= nxt;
            dreq <= (nxt == REQ) || (nxt == XFER);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            db_q <= '0;
        end else begin
            rd_q <= rd_act;
            wr_q <= wr_act;
            if (wr_act)
                db_q <= bus.DB_IN;
        end
    end

    // Set has priority over clear for both sticky flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tc_flag  <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (eop_hit)
                tc_flag <= 1'b1;
            else if (tc_clr)
                tc_flag <= 1'b0;
            if (ovf_set)
                ovf_flag <= 1'b1;
            else if (tc_clr)
                ovf_flag <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            src_wp <= '0;
            src_rp <= '0;
            snk_wp <= '0;
            snk_rp <= '0;
        end else begin
            if (src_push)
                src_wp <= src_wp + PTR_ONE;
            if (src_pop)
                src_rp <= src_rp + PTR_ONE;
            if (snk_push)
                snk_wp <= snk_wp + PTR_ONE;
            if (snk_pop)
                snk_rp <= snk_rp + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (src_push)
            src_mem[src_wp[AW-1:0]] <= src_data;
        if (snk_push)
            snk_mem[snk_wp[AW-1:0]] <= db_q;
    end

endmodule

// File: doc/dma_io_peripheral.md
DMA_IO_PERIPHERAL -- requirements
Module: dma_io_peripheral

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the entry count of each FIFO (power of 2, >=2).
REQ-002 Parameter WIDTH, default 8, SHALL set the data bus width.
REQ-003 CLK  in  1  single clock; all state SHALL update on posedge CLK.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 DREQ  out  1  DMA request to the controller channel, active high.
REQ-006 DACK  in  1  DMA acknowledge from the controller, active high.
REQ-007 IOR_N  in  1  I/O read strobe, active low (device drives bus).
REQ-008 IOW_N  in  1  I/O write strobe, active low (device captures bus).
REQ-009 EOP_N  in  1  end of process from the controller, active low.
REQ-010 DB_IN  in  WIDTH  bus data sampled on DMA writes.
REQ-011 DB_OUT  out  WIDTH  bus data driven on DMA reads.
REQ-012 DB_OE  out  1  DB_OUT output enable.
REQ-013 enable  in  1  local enable for request generation.
REQ-014 dir  in  1  0 = device-to-memory (DMA uses IOR_N), 1 = memory-to-device (DMA uses IOW_N).
REQ-015 src_valid/src_data/src_ready  in/in(WIDTH)/out  local push into the source FIFO.
REQ-016 snk_valid/snk_data/snk_ready  out/out(WIDTH)/in  local pop from the sink FIFO.
REQ-017 tc_flag  out  1  sticky terminal count; tc_clr  in  1  clears tc_flag.
REQ-018 ovf_flag  out  1  sticky sink-overflow error, cleared by tc_clr.

Function
REQ-019 FSM states SHALL be IDLE, REQ, XFER, RECOV, encoded one-hot.
REQ-020 IDLE->REQ SHALL occur when enable=1, tc_flag=0, and either (dir=0 and source FIFO not empty) or (dir=1 and sink FIFO not full).
REQ-021 DREQ SHALL be registered: 1 in REQ and XFER, 0 otherwise.
REQ-022 REQ->XFER SHALL occur on the first cycle DACK=1; REQ->IDLE SHALL occur if enable falls before DACK.
REQ-023 In XFER, DB_OE SHALL equal DACK & ~IOR_N & ~dir (combinational); DB_OUT SHALL show the source FIFO head at all times.
REQ-024 A read completes on the first cycle IOR_N=1 following a registered IOR_N=0 while DACK=1 and dir=0; the source FIFO SHALL pop one entry on that cycle.
REQ-025 During XFER, DB_IN SHALL be registered every cycle IOW_N=0 & DACK=1; on the IOW_N rising edge the last registered value SHALL be pushed to the sink FIFO.
REQ-026 A write completing while the sink FIFO is full SHALL drop the data and set ovf_flag.
REQ-027 On strobe completion the FSM SHALL go XFER->RECOV; RECOV SHALL last exactly one cycle, then IDLE (single-transfer mode: DREQ low for >=2 cycles between transfers).
REQ-028 DACK falling in XFER with no strobe completed SHALL return the FSM to REQ, with no FIFO change.
REQ-029 EOP_N=0 sampled while DACK=1 SHALL set tc_flag; the current transfer still completes; the FSM then stays in IDLE until tc_flag clears.
REQ-030 tc_clr and EOP_N in the same cycle SHALL leave tc_flag set (set wins).
REQ-031 FIFO pointers SHALL be log2(DEPTH)+1 bits wrapping modulo 2*DEPTH; full = MSBs differ and LSBs equal.
REQ-032 src_ready SHALL be high when the source FIFO is not full; snk_valid SHALL be high when the sink FIFO is not empty.
REQ-033 A simultaneous local push and bus pop on the same FIFO SHALL both take effect and leave the count unchanged, including when the FIFO is full.
REQ-034 The IOR_N and IOW_N strobes SHALL be ignored when DACK=0 or the strobe does not match dir.

Reset
REQ-035 RESET_N=0 SHALL immediately force: FSM=IDLE, DREQ=0, DB_OE=0, both FIFOs empty, tc_flag=0, ovf_flag=0, src_ready=1, snk_valid=0, DB_OUT=0.
REQ-036 Reset asserted mid-XFER SHALL abort the transfer with no FIFO push or pop.

Verification
REQ-037 dir=0, push 0xA5, enable=1 -> DREQ=1 within 2 cycles; DACK=1, IOR_N low 2 cycles -> DB_OE=1, DB_OUT=0xA5; IOR_N rises -> FIFO empty, DREQ=0 for 2 cycles, then stays 0.
REQ-038 dir=1, empty sink FIFO; DACK=1, DB_IN=0x3C with IOW_N low -> after the IOW_N rise, snk_valid=1 and snk_data=0x3C.
REQ-039 dir=1, sink FIFO filled with DEPTH entries -> DREQ stays 0; a forced write -> ovf_flag=1 and count stays DEPTH.
REQ-040 EOP_N=0 during the 3rd read of 5 queued bytes -> tc_flag=1, 2 bytes remain, DREQ=0 until tc_clr pulses, then DREQ=1.
REQ-041 RESET_N low while IOR_N=0 in XFER -> DREQ=0 and DB_OE=0 in the same cycle; after release, src_ready=1 and FIFO empty.
REQ-042 DEPTH=8: push 8, pop 8 via DMA, repeat twice -> pointers wrap and data order is preserved.
